// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: boots from RESET_PC, steps the PC on each accepted
// fetch, redirects on taken branches and stops on HALT. Define PC_BRANCH_STATS_EN
// to add the o_taken_count output (saturating count of taken redirects).
module pc_sequencer #(
    parameter int PC_WIDTH = 10,
    parameter int RESET_PC = 0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_stall,
    input  logic                i_branch_valid,
    input  logic                i_condition_met,
    input  logic [PC_WIDTH-1:0] i_branch_target,
    input  logic                i_halt,
    input  logic                i_imem_ready,
    output logic                o_imem_req,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [PC_WIDTH-1:0] o_pc_plus1,
    output logic                o_flush,
    output logic                o_halted
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [15:0]         o_taken_count
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_RST = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    state_t              state;
    logic [PC_WIDTH-1:0] pc_q;
    logic                taken;
    logic                accept;

    assign taken      = i_branch_valid & i_condition_met;
    assign o_imem_req = (state == FETCH) & ~i_stall;
    assign accept     = o_imem_req & i_imem_ready;
    assign o_pc       = pc_q;
    assign o_pc_plus1 = pc_q + PC_ONE;

    // Halt outranks a taken branch, which outranks stall and the handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            pc_q     <= PC_RST;
            o_flush  <= 1'b0;
            o_halted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state   <= FETCH;
                    o_flush <= 1'b0;
                end
                FETCH: begin
                    if (i_halt) begin
                        state    <= HALT;
                        o_halted <= 1'b1;
                    end else if (taken) begin
                        pc_q    <= i_branch_target;
                        o_flush <= 1'b1;
                        state   <= REDIRECT;
                    end else if (accept) begin
                        pc_q <= o_pc_plus1;
                    end
                end
                REDIRECT: begin
                    o_flush <= 1'b0;
                    state   <= FETCH;
                end
                HALT: begin
                    o_halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PC_BRANCH_STATS_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_taken_count <= 16'd0;
        end else if ((state == FETCH) && !i_halt && taken) begin
            o_taken_count <= sat_inc16(o_taken_count);
        end
    end
`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 10, fetch address width.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-003 SHALL have port i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_stall  input  1  hazard stall; hold PC.
REQ-006 SHALL have port i_branch_valid  input  1  branch/jump resolved this cycle.
REQ-007 SHALL have port i_condition_met  input  1  branch-decision result; taken when high with i_branch_valid.
REQ-008 SHALL have port i_branch_target  input  PC_WIDTH  redirect address.
REQ-009 SHALL have port i_halt  input  1  HALT instruction decoded.
REQ-010 SHALL have port i_imem_ready  input  1  instruction memory accepts current request.
REQ-011 SHALL have port o_imem_req  output  1  fetch request valid.
REQ-012 SHALL have port o_pc  output  PC_WIDTH  current fetch address, driven to instruction memory.
REQ-013 SHALL have port o_pc_plus1  output  PC_WIDTH  o_pc+1 modulo 2^PC_WIDTH, combinational.
REQ-014 SHALL have port o_flush  output  1  one-cycle pulse discarding wrong-path instruction.
REQ-015 SHALL have port o_halted  output  1  sequencer halted.

Function
REQ-016 SHALL implement states IDLE, FETCH, REDIRECT, HALT.
REQ-017 IDLE SHALL drive o_imem_req=0 and go to FETCH after exactly one cycle; all inputs ignored.
REQ-018 FETCH SHALL drive o_imem_req=~i_stall; priority per cycle: i_halt > taken branch > i_stall > handshake.
REQ-019 FETCH with i_halt=1 SHALL go to HALT; PC held.
REQ-020 FETCH with i_branch_valid&i_condition_met SHALL load PC<=i_branch_target, assert o_flush the next cycle, go to REDIRECT; any same-cycle handshake is discarded.
REQ-021 FETCH with i_branch_valid&~i_condition_met SHALL behave as if i_branch_valid=0.
REQ-022 FETCH with i_stall=1 (no halt/taken branch) SHALL hold PC, drive o_imem_req=0.
REQ-023 FETCH with o_imem_req&i_imem_ready SHALL advance PC to o_pc_plus1 next edge; without i_imem_ready PC and o_imem_req hold.
REQ-024 PC increment SHALL wrap from 2^PC_WIDTH-1 to 0 without error.
REQ-025 REDIRECT SHALL last exactly one cycle with o_imem_req=0, o_flush=1, then return to FETCH; i_branch_valid, i_stall and i_halt ignored there.
REQ-026 HALT SHALL be sticky until reset: o_halted=1, o_imem_req=0, PC frozen.
REQ-027 o_flush, o_halted SHALL be registered; o_imem_req combinational from state and i_stall only.

Reset
REQ-028 i_rst_n low SHALL immediately force state=IDLE, PC=RESET_PC, o_flush=0, o_halted=0, o_imem_req=0, regardless of clock.
REQ-029 Reset asserted mid-REDIRECT or mid-HALT SHALL abort it; first fetch after release is RESET_PC, two edges after deassertion.

Configuration
REQ-030 Macro PC_BRANCH_STATS_EN SHALL, when defined, add output o_taken_count (16 bits): count of accepted taken redirects (REQ-020), reset to 0, saturating at 16'hFFFF.
REQ-031 Without PC_BRANCH_STATS_EN, o_taken_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset release, i_imem_ready=1 held -> o_pc 0,0(IDLE),0,1,2,3 on successive cycles; o_imem_req rises on cycle 2.
REQ-033 PC=5 in FETCH, i_branch_valid=1, i_condition_met=1, target=0x120, i_imem_ready=1 -> o_pc=0x120, o_flush=1 and o_imem_req=0 one cycle, then fetch 0x120; o_taken_count=1 when enabled.
REQ-034 PC=5, i_branch_valid=1, i_condition_met=0, i_imem_ready=1 -> o_pc=6, o_flush stays 0, count unchanged.
REQ-035 PC=0x3FF (PC_WIDTH=10), ready=1 -> o_pc=0x000; i_stall=1 for 3 cycles -> PC held, o_imem_req=0 those cycles.
REQ-036 i_halt=1 and taken branch same cycle at PC=7 -> HALT, o_pc=7, o_halted=1, o_flush=0; later i_rst_n low -> o_pc=RESET_PC, o_halted=0 asynchronously.
